// File: rtl/fp32_to_bf16_converter.sv
// Two-stage streaming FP32 -> BF16 narrowing converter with RNE/truncate rounding and
// saturating overflow/NaN counters. Define BF16_FTZ_EN to flush FP32 subnormals to signed zero.
module fp32_to_bf16_converter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ROUND_MODE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      I_DATA,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [15:0]      O_DATA,
    output logic             O_VALID,
    input  logic             O_READY,
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] OVF_CNT,
    output logic [CNT_W-1:0] NAN_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_v_q, s1_v_d;
    logic [15:0]      s1_data_q, s1_data_d;
    logic             s2_v_q, s2_v_d;
    logic [15:0]      o_data_q, o_data_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

    logic [31:0] src;
    logic [15:0] rounded;
    logic [15:0] conv;
    logic        round_up;
    logic        is_nan;
    logic        is_ovf;
    logic        accept;
    logic        s2_load;

    assign I_READY = !s1_v_q || !s2_v_q || O_READY;
    assign O_DATA  = o_data_q;
    assign O_VALID = s2_v_q;
    assign OVF_CNT = ovf_cnt_q;
    assign NAN_CNT = nan_cnt_q;

    // Classification and rounding of the incoming operand
    always_comb begin
        src      = I_DATA;
        conv     = 16'h0000;
        is_nan   = 1'b0;
        is_ovf   = 1'b0;
`ifdef BF16_FTZ_EN
        if (I_DATA[30:23] == 8'h00 && I_DATA[22:0] != 23'd0) begin
            src = {I_DATA[31], 31'd0};
        end
`endif
        round_up = (ROUND_MODE == 0) && src[15] && ((|src[14:0]) || src[16]);
        rounded  = src[31:16] + 16'(round_up);
        if (I_DATA[30:23] == 8'hFF && I_DATA[22:0] != 23'd0) begin
            conv   = {I_DATA[31], 8'hFF, 1'b1, I_DATA[21:16]};
            is_nan = 1'b1;
        end else if (I_DATA[30:23] == 8'hFF) begin
            conv = {I_DATA[31], 15'h7F80};
        end else begin
            conv   = rounded;
            is_ovf = (rounded[14:7] == 8'hFF);
        end
    end

    // Handshake, pipeline advance and counter next-state
    always_comb begin
        accept    = I_VALID && I_READY;
        s2_load   = !s2_v_q || O_READY;
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s2_v_d    = s2_v_q;
        o_data_d  = o_data_q;
        ovf_cnt_d = ovf_cnt_q;
        nan_cnt_d = nan_cnt_q;

        if (accept) begin
            s1_v_d    = 1'b1;
            s1_data_d = conv;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                o_data_d = s1_data_q;
            end
        end

        // Clear wins over a coincident increment
        if (CLR_CNT) begin
            ovf_cnt_d = '0;
            nan_cnt_d = '0;
        end else begin
            if (accept && is_ovf && ovf_cnt_q != CNT_MAX) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
            if (accept && is_nan && nan_cnt_q != CNT_MAX) begin
                nan_cnt_d = nan_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= 16'h0000;
            s2_v_q    <= 1'b0;
            o_data_q  <= 16'h0000;
            ovf_cnt_q <= '0;
            nan_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s2_v_q    <= s2_v_d;
            o_data_q  <= o_data_d;
            ovf_cnt_q <= ovf_cnt_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp32_to_bf16_converter.sv
// Scoreboard bench: an RNE converter and a truncating converter (1-bit counters) share stimulus.
// Subnormal expectations follow BF16_FTZ_EN.
module tb_fp32_to_bf16_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_data = 32'd0;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b1;
    logic        clr_cnt = 1'b0;

    logic        i_ready, i_ready_t;
    logic [15:0] o_data, o_data_t;
    logic        o_valid, o_valid_t;
    logic [15:0] ovf_cnt, nan_cnt;
    logic [0:0]  ovf_cnt_t, nan_cnt_t;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb[$];
    logic [31:0] e;
    logic        stall_q = 1'b0;
    logic [15:0] held = 16'h0;

    always #5 clk = ~clk;

    fp32_to_bf16_converter #(.CNT_W(16), .ROUND_MODE(0)) dut (
        .CLK(clk), .RST(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready),
        .O_DATA(o_data), .O_VALID(o_valid), .O_READY(o_ready), .CLR_CNT(clr_cnt),
        .OVF_CNT(ovf_cnt), .NAN_CNT(nan_cnt)
    );

    fp32_to_bf16_converter #(.CNT_W(1), .ROUND_MODE(1)) dut_t (
        .CLK(clk), .RST(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready_t),
        .O_DATA(o_data_t), .O_VALID(o_valid_t), .O_READY(o_ready), .CLR_CNT(clr_cnt),
        .OVF_CNT(ovf_cnt_t), .NAN_CNT(nan_cnt_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output side: pop the scoreboard on every transfer, and police stall stability
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(held));
            end
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_output: observed=%h expected=none", o_data);
                end else begin
                    e = sb.pop_front();
                    chk("data_rne", 32'(o_data), 32'(e[31:16]));
                    chk("data_trunc", 32'(o_data_t), 32'(e[15:0]));
                    chk("valid_trunc", 32'(o_valid_t), 32'd1);
                end
            end
            stall_q = o_valid && !o_ready;
            held    = o_data;
        end
    end

    task automatic wait_accept(input logic [15:0] exp_rne, input logic [15:0] exp_trunc);
        int n = 0;
        @(negedge clk);
        while (!i_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!i_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed=i_ready low expected=accept within 20 cycles");
        end else begin
            sb.push_back({exp_rne, exp_trunc});
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic [15:0] exp_rne, input logic [15:0] exp_trunc);
        i_valid = 1'b1;
        i_data  = d;
        wait_accept(exp_rne, exp_trunc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_nan", 32'(nan_cnt), 32'd0);

        // Rounding ties and ordinary values, streamed back to back
        send(32'h3F808000, 16'h3F80, 16'h3F80);
        send(32'h3F818000, 16'h3F82, 16'h3F81);
        send(32'h3F808001, 16'h3F81, 16'h3F80);
        send(32'h3F800000, 16'h3F80, 16'h3F80);
        send(32'h40490FDB, 16'h4049, 16'h4049);
        send(32'h80000000, 16'h8000, 16'h8000);
        send(32'hFF800000, 16'hFF80, 16'hFF80);

        // Overflow to infinity
        send(32'h7F7FFFFF, 16'h7F80, 16'h7F7F);
        chk("ovf_1", 32'(ovf_cnt), 32'd1);
        send(32'hFF7FFFFF, 16'hFF80, 16'hFF7F);
        chk("ovf_2", 32'(ovf_cnt), 32'd2);
        send(32'h7F800000, 16'h7F80, 16'h7F80);
        chk("ovf_inf_unchanged", 32'(ovf_cnt), 32'd2);
        chk("ovf_trunc_none", 32'(ovf_cnt_t), 32'd0);
        chk("nan_none_yet", 32'(nan_cnt), 32'd0);

        // NaN quieting and counting; 1-bit counter saturates
        send(32'h7FC00001, 16'h7FC0, 16'h7FC0);
        send(32'hFF800001, 16'hFFC0, 16'hFFC0);
        chk("nan_2", 32'(nan_cnt), 32'd2);
        chk("nan_trunc_sat", 32'(nan_cnt_t), 32'd1);
        i_valid = 1'b1;
        i_data  = 32'h7F812345;
        clr_cnt = 1'b1;
        wait_accept(16'h7FC1, 16'h7FC1);
        clr_cnt = 1'b0;
        chk("nan_clr_prio", 32'(nan_cnt), 32'd0);
        chk("ovf_clr", 32'(ovf_cnt), 32'd0);
        chk("nan_trunc_clr", 32'(nan_cnt_t), 32'd0);

        // Subnormals
`ifdef BF16_FTZ_EN
        send(32'h00010000, 16'h0000, 16'h0000);
        send(32'h80018000, 16'h8000, 16'h8000);
        send(32'h007FFFFF, 16'h0000, 16'h0000);
`else
        send(32'h00010000, 16'h0001, 16'h0001);
        send(32'h80018000, 16'h8002, 16'h8001);
        send(32'h007FFFFF, 16'h0080, 16'h007F);
`endif
        chk("sub_no_ovf", 32'(ovf_cnt), 32'd0);
        idle(4);

        // Backpressure: two entries fill the pipe, third waits
        o_ready = 1'b0;
        send(32'h3F800000, 16'h3F80, 16'h3F80);
        send(32'h40000000, 16'h4000, 16'h4000);
        i_valid = 1'b1;
        i_data  = 32'h40400000;
        repeat (3) begin
            @(negedge clk);
            chk("bp_i_ready", 32'(i_ready), 32'd0);
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_data", 32'(o_data), 32'h3F80);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(i_ready), 32'd1);
        sb.push_back({16'h4040, 16'h4040});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("bp_stream_2", 32'(o_valid), 32'd1);
        @(negedge clk);
        chk("bp_stream_3", 32'(o_valid), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(o_valid), 32'd0);
        idle(2);
        chk("sb_drained", sb.size(), 32'd0);

        // Reset with two entries in flight
        o_ready = 1'b0;
        send(32'h7F7FFFFF, 16'h7F80, 16'h7F7F);
        send(32'h7FC00001, 16'h7FC0, 16'h7FC0);
        chk("pre_rst_full", 32'(i_ready), 32'd0);
        chk("pre_rst_ovf", 32'(ovf_cnt), 32'd1);
        chk("pre_rst_nan", 32'(nan_cnt), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_i_ready", 32'(i_ready), 32'd1);
        chk("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("mid_rst_nan", 32'(nan_cnt), 32'd0);
        chk("mid_rst_nan_t", 32'(nan_cnt_t), 32'd0);
        o_ready = 1'b1;
        idle(6);
        chk("post_rst_o_valid", 32'(o_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
